// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter
// Shares the fabric LED bank between several pattern sources (bit 0 = blinky).
// The bank stays dark until device init and the fabric PLL are both good. One
// owner at a time is granted in round-robin order. Each grant is held for at
// least MIN_HOLD cycles. With contention, a grant is preempted after MAX_SLICE
// cycles. The owner's pattern word is registered onto the LED pins.
//
// Optional feature: define LED_BANK_ARB_PWM_EN to add an 8-bit `duty` input.
// The LED drive is then gated by a free-running PWM counter. Without the
// macro, the captured word drives the pins directly.

module led_bank_arbiter #(
   parameter int NREQ      = 3,
   parameter int LED_W     = 12,
   parameter int MIN_HOLD  = 16,
   parameter int MAX_SLICE = 4096
) (
   input  logic                    clkin,
   input  logic                    rst_n,
   input  logic                    init_done,
   input  logic                    pll_lock,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*LED_W-1:0]   led_data,
`ifdef LED_BANK_ARB_PWM_EN
   input  logic [7:0]              duty,
`endif
   output logic [NREQ-1:0]         gnt,
   output logic [LED_W-1:0]        leds,
   output logic                    busy
);

   // Owner index width and hold counter width.
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HW = $clog2(MAX_SLICE);

   // Last hold_cnt value before a voluntary release is allowed.
   localparam logic [HW-1:0] HOLD_MIN_LAST = HW'(MIN_HOLD - 1);
   // Saturation value; reaching it with a pending requester forces a handover.
   localparam logic [HW-1:0] HOLD_SAT      = HW'(MAX_SLICE - 1);

   typedef enum logic [1:0] {
      ST_WAIT_INIT = 2'd0,
      ST_IDLE      = 2'd1,
      ST_GRANT     = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t            state_reg,      state_next;
   logic [OW-1:0]     owner_reg,      owner_next;
   logic [OW-1:0]     last_owner_reg, last_owner_next;
   logic [HW-1:0]     hold_cnt_reg,   hold_cnt_next;
   logic [LED_W-1:0]  led_q_reg,      led_q_next;
   logic [LED_W-1:0]  leds_reg,       leds_next;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic              sys_ready;
   logic [NREQ-1:0]   owner_oh;
   logic [LED_W-1:0]  data_word [NREQ];
   logic              owner_req;
   logic [NREQ-1:0]   others_req;
   logic [OW:0]       idle_pick;
   logic [OW:0]       hand_pick;
   logic              do_release;
   logic              do_preempt;

   assign sys_ready = init_done & pll_lock;

   // Split the pattern bus into words and decode the owner index to one-hot.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign data_word[gi] = led_data[gi*LED_W +: LED_W];
      assign owner_oh[gi]  = (owner_reg == OW'(gi));
   end

   assign owner_req  = req[owner_reg];
   assign others_req = req & ~owner_oh;

   // Round-robin search: the first set bit of mask at base+1, base+2, ...
   // (mod NREQ). base itself is checked last, so a requester that just owned
   // the bank has the lowest priority. Returns {found, index}.
   function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] mask,
                                           input logic [OW-1:0]   base);
      logic [OW:0]   result;
      logic [OW-1:0] sel;
      int            idx;
      result = '0;
      // Walk from the farthest candidate to the nearest so the nearest wins.
      for (int k = NREQ; k >= 1; k--) begin
         idx = int'(base) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         sel = OW'(idx);
         if (mask[sel]) begin
            result = {1'b1, sel};
         end
      end
      return result;
   endfunction

   assign idle_pick = rr_pick(req, last_owner_reg);
   assign hand_pick = rr_pick(others_req, owner_reg);

   // Voluntary release needs the minimum hold to be served. Preemption only
   // happens when someone else is actually waiting.
   assign do_release = !owner_req && (hold_cnt_reg >= HOLD_MIN_LAST);
   assign do_preempt = (hold_cnt_reg == HOLD_SAT) && hand_pick[OW];

   // ------------------------------------------------------------------
   // FSM state register and arbitration bookkeeping
   // ------------------------------------------------------------------
   // Register the arbiter state, the current owner, the round-robin pointer and the hold counter.
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         state_reg      <= ST_WAIT_INIT;
         owner_reg      <= '0;
         last_owner_reg <= OW'(NREQ - 1);
         hold_cnt_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         hold_cnt_reg   <= hold_cnt_next;
      end
   end

   // Compute the next state: gate on readiness, grant from IDLE, and handle release, handover or preemption in GRANT.
   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      hold_cnt_next   = hold_cnt_reg;

      if (!sys_ready) begin
         // Losing init or PLL lock drops everything, whatever the state.
         state_next    = ST_WAIT_INIT;
         hold_cnt_next = '0;
      end else begin
         unique case (state_reg)
            ST_WAIT_INIT: begin
               state_next    = ST_IDLE;
               hold_cnt_next = '0;
            end

            ST_IDLE: begin
               hold_cnt_next = '0;
               if (idle_pick[OW]) begin
                  state_next      = ST_GRANT;
                  owner_next      = idle_pick[OW-1:0];
                  last_owner_next = idle_pick[OW-1:0];
               end
            end

            ST_GRANT: begin
               // Count the time the owner has held the bank, saturating at the slice limit.
               if (hold_cnt_reg != HOLD_SAT) begin
                  hold_cnt_next = hold_cnt_reg + 1'b1;
               end

               if (do_release || do_preempt) begin
                  if (hand_pick[OW]) begin
                     // Direct handover: the grant moves on this edge with no idle gap.
                     owner_next      = hand_pick[OW-1:0];
                     last_owner_next = hand_pick[OW-1:0];
                     hold_cnt_next   = '0;
                  end else begin
                     state_next    = ST_IDLE;
                     hold_cnt_next = '0;
                  end
               end
            end

            default: begin
               state_next    = ST_WAIT_INIT;
               hold_cnt_next = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // LED datapath
   // ------------------------------------------------------------------
   // Capture the owner's word only while its request is high. After an early
   // drop (or a release), the bank keeps showing the last word captured.
   // Non-owners never reach this path.
   always_comb begin
      led_q_next = led_q_reg;
      if (!sys_ready) begin
         led_q_next = '0;
      end else if ((state_reg == ST_GRANT) && owner_req) begin
         led_q_next = data_word[owner_reg];
      end
   end

`ifdef LED_BANK_ARB_PWM_EN
   logic [7:0] pwm_cnt_reg;
   logic       pwm_on;

   assign pwm_on = (pwm_cnt_reg < duty);

   // Advance the free-running PWM phase counter. duty=0 never lights the bank; duty=255 lights it 255 of 256 cycles.
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         pwm_cnt_reg <= '0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      end
   end

   // Gate the word being captured, so the pins still lag led_data by one cycle.
   always_comb begin
      leds_next = led_q_next & {LED_W{pwm_on}};
      if (!sys_ready) begin
         leds_next = '0;
      end
   end
`else
   // Without PWM, the pins carry the captured word directly.
   always_comb begin
      leds_next = led_q_next;
   end
`endif

   // Register the captured word and the pin drive.
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         led_q_reg <= '0;
         leds_reg  <= '0;
      end else begin
         led_q_reg <= led_q_next;
         leds_reg  <= leds_next;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign busy = (state_reg == ST_GRANT);
   assign gnt  = busy ? owner_oh : '0;
   assign leds = leds_reg;

endmodule
